// File: rtl/nes_mem_arbiter_if.sv
// Bundle of the loader, PPU, CPU and memory-controller signals around the game memory arbiter.
// slave = arbiter side, master = requesters plus memory controller.
interface nes_mem_arbiter_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8
);
    logic              ld_write;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_overflow;
    logic              ld_busy;

    logic              ppu_req;
    logic [ADDR_W-1:0] ppu_addr;
    logic              ppu_ack;
    logic [DATA_W-1:0] ppu_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  ld_write, ld_addr, ld_data,
        input  ppu_req, ppu_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata, mem_ready,
        output ld_overflow, ld_busy,
        output ppu_ack, ppu_rdata,
        output cpu_ack, cpu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ld_write, ld_addr, ld_data,
        output ppu_req, ppu_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata, mem_ready,
        input  ld_overflow, ld_busy,
        input  ppu_ack, ppu_rdata,
        input  cpu_ack, cpu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/nes_mem_arbiter.sv
// Shares the single game-memory port between loader writes, PPU reads and CPU accesses.
// Define NES_ARB_STARVE_GUARD_EN to let the CPU overtake the PPU after MAX_WAIT PPU grants.
module nes_mem_arbiter #(
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    nes_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;
    typedef enum logic [1:0] {W_LD, W_PPU, W_CPU} src_t;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_check
        $error("MAX_WAIT must be in 1..15");
    end

    state_t            state_q, state_d;
    src_t              win_q, win_d;
    logic              grant;
    logic              cpu_first;

    logic              buf_vld_q, buf_vld_d;
    logic              buf_take, buf_load;
    logic [ADDR_W-1:0] buf_addr_q;
    logic [DATA_W-1:0] buf_data_q;
    logic              ovf_q, ovf_d;

    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rd_done;
    logic [DATA_W-1:0] ppu_rdata_q, ppu_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

`ifdef NES_ARB_STARVE_GUARD_EN
    localparam logic [3:0] WaitLim = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;

    assign cpu_first = (wait_cnt_q >= WaitLim);

    // Counts PPU wins the CPU had to sit through; saturates rather than wrapping.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (grant && win_d == W_CPU) begin
            wait_cnt_d = '0;
        end else if (grant && win_d == W_PPU && bus.cpu_req && wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wait_cnt_q <= '0;
        else        wait_cnt_q <= wait_cnt_d;
    end
`else
    assign cpu_first = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        grant   = 1'b0;
        case (state_q)
            S_IDLE: begin
                grant = 1'b1;
                if (buf_vld_q)                      win_d = W_LD;
                else if (bus.cpu_req && cpu_first)  win_d = W_CPU;
                else if (bus.ppu_req)               win_d = W_PPU;
                else if (bus.cpu_req)               win_d = W_CPU;
                else                                grant = 1'b0;
                if (grant) state_d = S_BUSY;
            end
            S_BUSY:  if (bus.mem_ready) state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The memory-side registers only move at a grant, so they hold after mem_req drops.
    always_comb begin
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (grant) begin
            case (win_d)
                W_LD: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = buf_addr_q;
                    mem_wdata_d = buf_data_q;
                end
                W_PPU: begin
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.ppu_addr;
                end
                default: begin
                    mem_we_d    = bus.cpu_we;
                    mem_addr_d  = bus.cpu_addr;
                    mem_wdata_d = bus.cpu_wdata;
                end
            endcase
        end
    end

    assign rd_done     = (state_q == S_BUSY) && bus.mem_ready && !mem_we_q;
    assign ppu_rdata_d = (rd_done && win_q == W_PPU) ? bus.mem_rdata : ppu_rdata_q;
    assign cpu_rdata_d = (rd_done && win_q == W_CPU) ? bus.mem_rdata : cpu_rdata_q;

    // A write arriving in the cycle the entry is granted refills the freed slot.
    assign buf_take  = grant && (win_d == W_LD);
    assign buf_load  = bus.ld_write && (!buf_vld_q || buf_take);
    assign buf_vld_d = buf_load || (buf_vld_q && !buf_take);
    assign ovf_d     = ovf_q || (bus.ld_write && buf_vld_q && !buf_take);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            win_q       <= W_LD;
            buf_vld_q   <= 1'b0;
            ovf_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ppu_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            buf_vld_q   <= buf_vld_d;
            ovf_q       <= ovf_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ppu_rdata_q <= ppu_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_addr_q <= bus.ld_addr;
            buf_data_q <= bus.ld_data;
        end
    end

    assign bus.mem_req     = (state_q == S_BUSY);
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.ppu_ack     = (state_q == S_ACK) && (win_q == W_PPU);
    assign bus.cpu_ack     = (state_q == S_ACK) && (win_q == W_CPU);
    assign bus.ppu_rdata   = ppu_rdata_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.ld_overflow = ovf_q;
    assign bus.ld_busy     = buf_vld_q || ((state_q != S_IDLE) && (win_q == W_LD));
endmodule
